// File: rtl/aud_i2s_pkg.sv
// Shared types and parameter helpers for the I2S transmitter.
package aud_i2s_pkg;

   localparam int unsigned DATA_W_DEF = 16;

   // LRCK level identifies the channel being transmitted.
   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } aud_ch_e;

   // A half-frame needs the delay slot plus one slot per data bit.
   function automatic bit slots_fit(input int unsigned slots, input int unsigned data_w);
      return slots >= (data_w + 1);
   endfunction

endpackage

// File: rtl/aud_sync_fifo.sv
// Synchronous FIFO with single-word push and paired pop (two oldest words at once).
module aud_sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop2,
   output logic [WIDTH-1:0]         o_rd0,
   output logic [WIDTH-1:0]         o_rd1,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic [AW:0]      w_level_nxt;

   // Occupancy after this cycle's push and pair-pop; caller never pops with level < 2.
   always_comb begin
      w_level_nxt = r_level + (AW + 1)'(i_push) - ((AW + 1)'(i_pop2) << 1);
   end

   // Storage array; contents need no reset since pointers define validity.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and level; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (i_pop2) begin
            r_rd_ptr <= r_rd_ptr + AW'(2);
         end
         r_level <= w_level_nxt;
      end
   end

   assign o_rd0   = r_mem[r_rd_ptr];
   assign o_rd1   = r_mem[r_rd_ptr + AW'(1)];
   assign o_level = r_level;

endmodule

// File: rtl/aud_i2s_tx.sv
// Codec-side I2S transmitter: generates BCLK/LRCK and serializes queued L/R sample pairs.
module aud_i2s_tx
   import aud_i2s_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned SLOTS      = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [DATA_W-1:0]             i_data,
   output logic                          o_AUD_BCLK,
   output logic                          o_AUD_LRCK,
   output logic                          o_AUD_DAT,
   output logic                          o_underrun,
   input  logic                          i_clr_underrun,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

   if (!slots_fit(SLOTS, DATA_W)) begin : g_bad_slots
      $error("aud_i2s_tx: SLOTS must be at least DATA_W+1");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("aud_i2s_tx: CLK_DIV must be at least 1");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("aud_i2s_tx: FIFO_DEPTH must be a power of two and at least 2");
   end

   logic [DIV_W-1:0]  r_div,      w_div_nxt;
   logic              r_bclk,     w_bclk_nxt;
   aud_ch_e           r_lrck,     w_lrck_nxt;
   logic              r_dat,      w_dat_nxt;
   logic [SLOT_W-1:0] r_slot,     w_slot_nxt;
   logic [DATA_W-1:0] r_shift,    w_shift_nxt;
   logic [DATA_W-1:0] r_shadow_l, w_shadow_l_nxt;
   logic [DATA_W-1:0] r_shadow_r, w_shadow_r_nxt;
   logic              r_underrun, w_underrun_nxt;

   logic              w_tick;
   logic              w_fall;
   logic              w_push;
   logic              w_pop2;
   logic              w_have_pair;
   logic              w_set_underrun;
   logic [DATA_W-1:0] w_rd0;
   logic [DATA_W-1:0] w_rd1;
   logic [LVL_W-1:0]  w_level;

   aud_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (i_data),
      .i_pop2  (w_pop2),
      .o_rd0   (w_rd0),
      .o_rd1   (w_rd1),
      .o_level (w_level)
   );

   assign o_ready     = (w_level < LVL_W'(FIFO_DEPTH));
   assign w_push      = i_valid & o_ready;
   assign w_have_pair = (w_level >= LVL_W'(2));
   assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
   // BCLK is high whenever the divider wraps into a falling edge.
   assign w_fall      = w_tick & r_bclk;

   // Next-state for divider, framing, shift register, shadows and underrun flag.
   always_comb begin
      w_div_nxt      = r_div + DIV_W'(1);
      w_bclk_nxt     = r_bclk;
      w_lrck_nxt     = r_lrck;
      w_dat_nxt      = r_dat;
      w_slot_nxt     = r_slot;
      w_shift_nxt    = r_shift;
      w_shadow_l_nxt = r_shadow_l;
      w_shadow_r_nxt = r_shadow_r;
      w_pop2         = 1'b0;
      w_set_underrun = 1'b0;

      if (w_tick) begin
         w_div_nxt  = '0;
         w_bclk_nxt = ~r_bclk;
      end

      if (w_fall) begin
         w_slot_nxt = (r_slot == SLOT_W'(SLOTS - 1)) ? '0 : r_slot + SLOT_W'(1);
         w_dat_nxt  = 1'b0;
         if (r_slot == '0) begin
            // Slot 0: LRCK flips, DAT carries the one-bit I2S delay.
            w_lrck_nxt = (r_lrck == CH_LEFT) ? CH_RIGHT : CH_LEFT;
            if (w_lrck_nxt == CH_LEFT) begin
               if (w_have_pair) begin
                  w_pop2         = 1'b1;
                  w_shadow_l_nxt = w_rd0;
                  w_shadow_r_nxt = w_rd1;
                  w_shift_nxt    = w_rd0;
               end else begin
                  // Send a silent pair so L/R alignment survives starvation.
                  w_shadow_l_nxt = '0;
                  w_shadow_r_nxt = '0;
                  w_shift_nxt    = '0;
                  w_set_underrun = 1'b1;
               end
            end else begin
               w_shift_nxt = r_shadow_r;
            end
         end else if (r_slot <= SLOT_W'(DATA_W)) begin
            w_dat_nxt   = r_shift[DATA_W-1];
            w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
         end
      end

      // A new underrun wins over a simultaneous clear.
      if (w_set_underrun) begin
         w_underrun_nxt = 1'b1;
      end else if (i_clr_underrun) begin
         w_underrun_nxt = 1'b0;
      end else begin
         w_underrun_nxt = r_underrun;
      end
   end

   // State registers with synchronous reset; reset aborts any frame in progress.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div      <= '0;
         r_bclk     <= 1'b1;
         r_lrck     <= CH_RIGHT;
         r_dat      <= 1'b0;
         r_slot     <= '0;
         r_shift    <= '0;
         r_shadow_l <= '0;
         r_shadow_r <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_div      <= w_div_nxt;
         r_bclk     <= w_bclk_nxt;
         r_lrck     <= w_lrck_nxt;
         r_dat      <= w_dat_nxt;
         r_slot     <= w_slot_nxt;
         r_shift    <= w_shift_nxt;
         r_shadow_l <= w_shadow_l_nxt;
         r_shadow_r <= w_shadow_r_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   assign o_AUD_BCLK = r_bclk;
   assign o_AUD_LRCK = r_lrck;
   assign o_AUD_DAT  = r_dat;
   assign o_underrun = r_underrun;
   assign o_level    = w_level;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed self-checking bench for aud_i2s_tx with default parameters.
module tb_aud_i2s_tx;

   logic        clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_data;
   logic        o_AUD_BCLK;
   logic        o_AUD_LRCK;
   logic        o_AUD_DAT;
   logic        o_underrun;
   logic        i_clr_underrun;
   logic [2:0]  o_level;

   int   n_vec;
   int   n_err;
   int   cyc;
   logic prev_bclk;
   logic prev_lrck;
   logic fell;

   aud_i2s_tx u_dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_data         (i_data),
      .o_AUD_BCLK     (o_AUD_BCLK),
      .o_AUD_LRCK     (o_AUD_LRCK),
      .o_AUD_DAT      (o_AUD_DAT),
      .o_underrun     (o_underrun),
      .i_clr_underrun (i_clr_underrun),
      .o_level        (o_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      prev_bclk = o_AUD_BCLK;
      prev_lrck = o_AUD_LRCK;
      @(posedge clk);
      #1;
      cyc++;
      fell = prev_bclk & ~o_AUD_BCLK;
   endtask

   task automatic do_reset();
      i_rst          = 1'b1;
      i_valid        = 1'b0;
      i_data         = '0;
      i_clr_underrun = 1'b0;
      tick();
      tick();
      i_rst = 1'b0;
      cyc   = 0;
   endtask

   task automatic wait_fall();
      bit got;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (fell) got = 1;
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL bclk_fall_timeout got none want fall within 20 cycles");
      end
   endtask

   // Syncs to the next left slot 0 and records DAT/LRCK at 64 consecutive falls.
   task automatic capture_frame(output logic [63:0] dat, output logic [63:0] lr,
                                output logic [2:0] lvl0);
      bit found;
      found = 0;
      dat   = '0;
      lr    = '0;
      for (int i = 0; i < 600 && !found; i++) begin
         tick();
         if (fell && prev_lrck && !o_AUD_LRCK) found = 1;
      end
      if (!found) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_sync_timeout got none want left slot 0 within 600 cycles");
      end
      lvl0    = o_level;
      dat[63] = o_AUD_DAT;
      lr[63]  = o_AUD_LRCK;
      for (int k = 1; k < 64; k++) begin
         wait_fall();
         dat[63-k] = o_AUD_DAT;
         lr[63-k]  = o_AUD_LRCK;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_clr_underrun = 1'b0;
      tick();
      tick();
      n_vec++; if (o_AUD_BCLK !== 1'b1) begin n_err++; $display("FAIL rst_bclk got %b want 1", o_AUD_BCLK); end
      n_vec++; if (o_AUD_LRCK !== 1'b1) begin n_err++; $display("FAIL rst_lrck got %b want 1", o_AUD_LRCK); end
      n_vec++; if (o_AUD_DAT !== 1'b0) begin n_err++; $display("FAIL rst_dat got %b want 0", o_AUD_DAT); end
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL rst_underrun got %b want 0", o_underrun); end
      n_vec++; if (o_level !== 3'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", o_level); end
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", o_ready); end
      i_rst = 1'b0;
      cyc   = 0;
      tick();
      n_vec++; if (o_AUD_BCLK !== 1'b1) begin n_err++; $display("FAIL bclk_cyc1 got %b want 1", o_AUD_BCLK); end
      tick();
      n_vec++; if (o_AUD_BCLK !== 1'b0) begin n_err++; $display("FAIL bclk_first_fall got %b want 0", o_AUD_BCLK); end
      n_vec++; if (o_AUD_LRCK !== 1'b0) begin n_err++; $display("FAIL lrck_first_fall got %b want 0", o_AUD_LRCK); end
      n_vec++; if (o_underrun !== 1'b1) begin n_err++; $display("FAIL underrun_first_load got %b want 1", o_underrun); end
   endtask

   // Continues from cycle 2 of test_reset with an empty FIFO.
   task automatic test_idle();
      int   first_fall;
      int   lr_rise;
      int   lr_fall;
      logic dat_seen;
      first_fall = -1; lr_rise = -1; lr_fall = -1; dat_seen = 1'b0;
      while (cyc < 300) begin
         tick();
         if (fell && first_fall < 0) first_fall = cyc;
         if (o_AUD_LRCK && lr_rise < 0) lr_rise = cyc;
         if (!o_AUD_LRCK && lr_rise >= 0 && lr_fall < 0) lr_fall = cyc;
         if (o_AUD_DAT) dat_seen = 1'b1;
      end
      n_vec++; if (first_fall != 6) begin n_err++; $display("FAIL bclk_period got fall at %0d want 6", first_fall); end
      n_vec++; if (lr_rise != 130) begin n_err++; $display("FAIL lrck_right got %0d want 130", lr_rise); end
      n_vec++; if (lr_fall != 258) begin n_err++; $display("FAIL lrck_left got %0d want 258", lr_fall); end
      n_vec++; if (dat_seen !== 1'b0) begin n_err++; $display("FAIL idle_dat got %b want 0", dat_seen); end
   endtask

   task automatic test_data();
      logic [63:0] dat;
      logic [63:0] lr;
      logic [2:0]  lvl0;
      logic [63:0] exp_dat;
      exp_dat = {1'b0, 16'hA5C3, 15'd0, 1'b0, 16'h0001, 15'd0};
      do_reset();
      wait_fall();
      i_clr_underrun = 1'b1; tick(); i_clr_underrun = 1'b0;
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL clr_underrun got %b want 0", o_underrun); end
      i_valid = 1'b1; i_data = 16'hA5C3; tick();
      i_data = 16'h0001; tick();
      i_valid = 1'b0;
      n_vec++; if (o_level !== 3'd2) begin n_err++; $display("FAIL data_level got %0d want 2", o_level); end
      capture_frame(dat, lr, lvl0);
      n_vec++; if (dat !== exp_dat) begin n_err++; $display("FAIL data_frame got %h want %h", dat, exp_dat); end
      n_vec++; if (lr !== {32'h0, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL data_lrck got %h want %h", lr, {32'h0, 32'hFFFF_FFFF}); end
      n_vec++; if (lvl0 !== 3'd0) begin n_err++; $display("FAIL data_level_pop got %0d want 0", lvl0); end
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL data_underrun got %b want 0", o_underrun); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [5];
      logic [63:0] dat;
      logic [63:0] lr;
      logic [2:0]  lvl0;
      logic [63:0] exp_dat;
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
      words[3] = 16'h4444; words[4] = 16'h8001;
      exp_dat = {1'b0, 16'h8001, 15'd0, 1'b0, 16'h7FFE, 15'd0};
      do_reset();
      wait_fall();
      i_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         i_data = words[i];
         tick();
      end
      n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", o_ready); end
      i_data = words[4];
      tick();
      n_vec++; if (o_level !== 3'd4) begin n_err++; $display("FAIL stall_level got %0d want 4", o_level); end
      while (cyc < 258) tick();
      n_vec++; if (o_level !== 3'd2) begin n_err++; $display("FAIL pop_level got %0d want 2", o_level); end
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL pop_ready got %b want 1", o_ready); end
      tick();
      i_valid = 1'b0;
      n_vec++; if (o_level !== 3'd3) begin n_err++; $display("FAIL refill_level got %0d want 3", o_level); end
      while (cyc < 513) tick();
      i_valid = 1'b1; i_data = 16'h7FFE;
      tick();
      i_valid = 1'b0;
      n_vec++; if (o_level !== 3'd2) begin n_err++; $display("FAIL push_pop_level got %0d want 2", o_level); end
      capture_frame(dat, lr, lvl0);
      n_vec++; if (dat !== exp_dat) begin n_err++; $display("FAIL order_frame got %h want %h", dat, exp_dat); end
      n_vec++; if (lvl0 !== 3'd0) begin n_err++; $display("FAIL order_level got %0d want 0", lvl0); end
   endtask

   task automatic test_partial();
      logic [63:0] dat;
      logic [63:0] lr;
      logic [2:0]  lvl0;
      logic [63:0] exp_dat;
      exp_dat = {1'b0, 16'hC0DE, 15'd0, 1'b0, 16'h1234, 15'd0};
      do_reset();
      wait_fall();
      i_clr_underrun = 1'b1; tick(); i_clr_underrun = 1'b0;
      i_valid = 1'b1; i_data = 16'hC0DE; tick(); i_valid = 1'b0;
      capture_frame(dat, lr, lvl0);
      n_vec++; if (dat !== 64'd0) begin n_err++; $display("FAIL partial_frame got %h want 0", dat); end
      n_vec++; if (lvl0 !== 3'd1) begin n_err++; $display("FAIL partial_level got %0d want 1", lvl0); end
      n_vec++; if (o_underrun !== 1'b1) begin n_err++; $display("FAIL partial_underrun got %b want 1", o_underrun); end
      i_valid = 1'b1; i_data = 16'h1234; tick(); i_valid = 1'b0;
      capture_frame(dat, lr, lvl0);
      n_vec++; if (dat !== exp_dat) begin n_err++; $display("FAIL partial_next got %h want %h", dat, exp_dat); end
      n_vec++; if (lvl0 !== 3'd0) begin n_err++; $display("FAIL partial_next_level got %0d want 0", lvl0); end
   endtask

   task automatic test_clr_collision();
      do_reset();
      tick();
      i_clr_underrun = 1'b1;
      tick();
      i_clr_underrun = 1'b0;
      n_vec++; if (o_underrun !== 1'b1) begin n_err++; $display("FAIL clr_vs_set got %b want 1", o_underrun); end
      tick();
      i_clr_underrun = 1'b1;
      tick();
      i_clr_underrun = 1'b0;
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL clr_later got %b want 0", o_underrun); end
   endtask

   task automatic test_midframe_reset();
      do_reset();
      wait_fall();
      i_valid = 1'b1; i_data = 16'hFFFF;
      tick(); tick(); tick();
      i_valid = 1'b0;
      while (cyc < 166) tick();
      n_vec++; if (!(fell && o_AUD_LRCK)) begin n_err++; $display("FAIL slot9_right got fell=%b lrck=%b want 1 1", fell, o_AUD_LRCK); end
      i_rst = 1'b1;
      tick();
      n_vec++; if (o_AUD_BCLK !== 1'b1) begin n_err++; $display("FAIL mid_bclk got %b want 1", o_AUD_BCLK); end
      n_vec++; if (o_AUD_LRCK !== 1'b1) begin n_err++; $display("FAIL mid_lrck got %b want 1", o_AUD_LRCK); end
      n_vec++; if (o_AUD_DAT !== 1'b0) begin n_err++; $display("FAIL mid_dat got %b want 0", o_AUD_DAT); end
      n_vec++; if (o_level !== 3'd0) begin n_err++; $display("FAIL mid_level got %0d want 0", o_level); end
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %b want 1", o_ready); end
      n_vec++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL mid_underrun got %b want 0", o_underrun); end
      i_rst = 1'b0;
      cyc   = 0;
      tick();
      tick();
      n_vec++; if (!(fell && o_AUD_LRCK === 1'b0)) begin n_err++; $display("FAIL restart_left got fell=%b lrck=%b want 1 0", fell, o_AUD_LRCK); end
      n_vec++; if (o_underrun !== 1'b1) begin n_err++; $display("FAIL restart_flushed got %b want 1", o_underrun); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      fell  = 1'b0;
      test_reset();
      test_idle();
      test_data();
      test_back_to_back();
      test_partial();
      test_clr_collision();
      test_midframe_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
